fp_issue_arbiter: RTL and testbench

//  Shares one fixed-latency FP execution pipeline (fp_alu wrapped as LATENCY register

---
 rtl/fp_issue_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fp_issue_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency FP pipeline between N_REQ requesters,
// with per-requester credit limits, a tag pipe that returns results to their owners, and flush/drain.
module fp_issue_arbiter #(
  parameter int N_REQ     = 2,
  parameter int LATENCY   = 3,
  parameter int OP_W      = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  input  logic [N_REQ*32-1:0]   req_c,
  output logic                  ex_valid,
  output logic [OP_W-1:0]       ex_op,
  output logic [31:0]           ex_a,
  output logic [31:0]           ex_b,
  output logic [31:0]           ex_c,
  input  logic [31:0]           ex_result,
  input  logic [4:0]            ex_flags,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_result,
  output logic [4:0]            rsp_flags,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [N_REQ];
  logic [CNT_W-1:0]  cnt_d [N_REQ];
  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [31:0]       ex_a_q, ex_a_d;
  logic [31:0]       ex_b_q, ex_b_d;
  logic [31:0]       ex_c_q, ex_c_d;
  logic [ID_W-1:0]   ex_id_q, ex_id_d;
  logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [ID_W-1:0]   tag_id_q [LATENCY];
  logic [ID_W-1:0]   tag_id_d [LATENCY];
  logic              flush_done_q, flush_done_d;

  logic [N_REQ-1:0]  eligible;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   grant;
  logic              found;
  logic              accept;
  logic              cnt_idle;
  logic              cnt_idle_nxt;
  logic              drained;

  // A credit returning this cycle may be reused by a same-cycle accept, so a saturated
  // requester streams without a bubble.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_valid_q[LATENCY-1] && tag_id_q[LATENCY-1] == ID_W'(i)) rsp_valid[i] = 1'b1;
    end
    cnt_idle = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && ((cnt_q[i] < CNT_W'(MAX_OUTST)) || rsp_valid[i]);
      if (cnt_q[i] != '0) cnt_idle = 1'b0;
    end
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    accept    = found && rst_n && (state_q == RUN) && !flush_req;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && grant == ID_W'(i)) req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ex_valid_d = accept;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_c_d     = ex_c_q;
    ex_id_d    = ex_id_q;
    if (accept) begin
      ex_id_d  = grant;
      rr_ptr_d = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (grant == ID_W'(i)) begin
          ex_op_d = req_op[i*OP_W +: OP_W];
          ex_a_d  = req_a[i*32 +: 32];
          ex_b_d  = req_b[i*32 +: 32];
          ex_c_d  = req_c[i*32 +: 32];
        end
      end
    end

    tag_valid_d[0] = ex_valid_q;
    tag_id_d[0]    = ex_id_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_id_d[i]    = tag_id_q[i-1];
    end

    cnt_idle_nxt = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_ready[i] && !rsp_valid[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!req_ready[i] && rsp_valid[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      if (cnt_d[i] != '0) cnt_idle_nxt = 1'b0;
    end

    drained = !ex_valid_q && (tag_valid_q == '0) && cnt_idle;
    case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (drained) begin
                 state_d  = RUN;
                 rr_ptr_d = '0;
               end
      default: state_d = RUN;
    endcase

    // Registered pulse that lines up with the DRAIN cycle in which everything is empty.
    flush_done_d = (state_d == DRAIN) && !ex_valid_d && (tag_valid_d == '0) && cnt_idle_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      rr_ptr_q     <= '0;
      ex_valid_q   <= 1'b0;
      ex_op_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_c_q       <= '0;
      ex_id_q      <= '0;
      tag_valid_q  <= '0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_c_q       <= ex_c_d;
      ex_id_q      <= ex_id_d;
      tag_valid_q  <= tag_valid_d;
      flush_done_q <= flush_done_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
      for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= tag_id_d[i];
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_op      = ex_op_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_c       = ex_c_q;
  assign rsp_result = ex_result;
  assign rsp_flags  = ex_flags;
  assign flush_done = flush_done_q;
  assign busy       = ex_valid_q || (tag_valid_q != '0) || !cnt_idle;

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Testbench for fp_issue_arbiter: a fake fixed-latency execution unit plus a queue-based
// reference model of issue order, credits, response timing and flush.
module tb_fp_issue_arbiter;

  localparam int N_REQ     = 2;
  localparam int LATENCY   = 3;
  localparam int OP_W      = 4;
  localparam int MAX_OUTST = 2;

  logic                  clk;
  logic                  rst_n;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*OP_W-1:0] req_op;
  logic [N_REQ*32-1:0]   req_a, req_b, req_c;
  logic                  ex_valid;
  logic [OP_W-1:0]       ex_op;
  logic [31:0]           ex_a, ex_b, ex_c;
  logic [31:0]           ex_result;
  logic [4:0]            ex_flags;
  logic [N_REQ-1:0]      rsp_valid;
  logic [31:0]           rsp_result;
  logic [4:0]            rsp_flags;
  logic                  flush_req;
  logic                  flush_done;
  logic                  busy;

  fp_issue_arbiter #(.N_REQ(N_REQ), .LATENCY(LATENCY), .OP_W(OP_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c),
    .ex_result(ex_result), .ex_flags(ex_flags),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the FP unit: a deterministic mix of the operands, delivered LATENCY cycles after issue.
  function automatic logic [31:0] eu_fn(input logic [OP_W-1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    return a ^ {b[30:0], b[31]} ^ {c[28:0], c[31:29]} ^ 32'(op);
  endfunction

  function automatic logic [4:0] flg_fn(input logic [OP_W-1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    r = eu_fn(op, a, b, c);
    return r[4:0] ^ r[31:27];
  endfunction

  logic [31:0] eu_res [LATENCY];
  logic [4:0]  eu_flg [LATENCY];

  always @(posedge clk) begin
    eu_res[0] <= ex_valid ? eu_fn(ex_op, ex_a, ex_b, ex_c) : $urandom;
    eu_flg[0] <= ex_valid ? flg_fn(ex_op, ex_a, ex_b, ex_c) : 5'($urandom);
    for (int i = 1; i < LATENCY; i++) begin
      eu_res[i] <= eu_res[i-1];
      eu_flg[i] <= eu_flg[i-1];
    end
  end

  assign ex_result = eu_res[LATENCY-1];
  assign ex_flags  = eu_flg[LATENCY-1];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] res;
    logic [4:0]  flg;
  } pend_t;

  pend_t           pend[$];
  int              cyc;
  int              m_rr;
  bit              m_drain;
  bit              m_issued;
  logic [OP_W-1:0] m_op;
  logic [31:0]     m_a, m_b, m_c;
  logic [N_REQ-1:0] e_ready, e_rsp;
  logic [31:0]     e_res;
  logic [4:0]      e_flg;
  bit              e_acc, e_fd, e_busy;
  int              e_g;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic model_reset();
    pend.delete();
    m_rr     = 0;
    m_drain  = 0;
    m_issued = 0;
    m_op     = '0;
    m_a      = '0;
    m_b      = '0;
    m_c      = '0;
  endtask

  // Expected outputs for the current cycle given the inputs just driven.
  task automatic model_eval();
    int outst[N_REQ];
    bit found;
    foreach (outst[i]) outst[i] = 0;
    foreach (pend[j]) outst[pend[j].id]++;
    e_rsp = '0;
    e_res = '0;
    e_flg = '0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      e_rsp[pend[0].id] = 1'b1;
      e_res = pend[0].res;
      e_flg = pend[0].flg;
    end
    found = 0;
    e_g   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (m_rr + k) % N_REQ;
      if (!found && req_valid[idx] && (outst[idx] < MAX_OUTST || e_rsp[idx])) begin
        found = 1;
        e_g   = idx;
      end
    end
    e_acc   = found && !m_drain && !flush_req && rst_n;
    e_ready = e_acc ? (N_REQ'(1) << e_g) : '0;
    e_busy  = pend.size() != 0;
    e_fd    = m_drain && pend.size() == 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_rsp != '0) void'(pend.pop_front());
    m_issued = e_acc;
    if (e_acc) begin
      m_op = req_op[e_g*OP_W +: OP_W];
      m_a  = req_a[e_g*32 +: 32];
      m_b  = req_b[e_g*32 +: 32];
      m_c  = req_c[e_g*32 +: 32];
      pend.push_back('{cyc + 1 + LATENCY, e_g, eu_fn(m_op, m_a, m_b, m_c), flg_fn(m_op, m_a, m_b, m_c)});
      m_rr = (e_g + 1) % N_REQ;
    end
    if (e_fd) begin
      m_drain = 0;
      m_rr    = 0;
    end else if (!m_drain && flush_req) begin
      m_drain = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_cycle(input logic [N_REQ-1:0] v, input bit fl);
    req_valid = v;
    flush_req = fl;
    for (int i = 0; i < N_REQ; i++) begin
      req_op[i*OP_W +: OP_W] = OP_W'($urandom);
      req_a[i*32 +: 32]      = $urandom;
      req_b[i*32 +: 32]      = $urandom;
      req_c[i*32 +: 32]      = $urandom;
    end
    #1;
    model_eval();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive_cycle('0, 1'b0);
      n_checks++; if (rsp_valid !== e_rsp) begin n_fail++; $display("[TB] FAIL idle_rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, e_rsp); end
      if (e_rsp != '0) begin
        n_checks++; if (rsp_result !== e_res) begin n_fail++; $display("[TB] FAIL idle_rsp_result cyc=%0d got %h exp %h", cyc, rsp_result, e_res); end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    flush_req = 1'b0;
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("[TB] FAIL reset_req_ready got %b exp 00", req_ready); end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ex_valid got %b exp 0", ex_valid); end
    n_checks++; if ({ex_op, ex_a, ex_b, ex_c} !== '0) begin n_fail++; $display("[TB] FAIL reset_ex_fields got %h %h %h %h exp 0", ex_op, ex_a, ex_b, ex_c); end
    n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flush_done got %b exp 0", flush_done); end
  endtask

  task automatic test_single_op();
    for (int c = 0; c < 10; c++) begin
      drive_cycle((c == 0) ? 2'b01 : 2'b00, 1'b0);
      req_op[0 +: OP_W] = '0;
      req_a[0 +: 32]    = 32'h3F800000;
      req_b[0 +: 32]    = 32'h40000000;
      req_c[0 +: 32]    = 32'h00000000;
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("[TB] FAIL single_ready c=%0d got %b exp %b", c, req_ready, e_ready); end
      n_checks++; if (ex_valid !== (c == 1)) begin n_fail++; $display("[TB] FAIL single_ex_valid c=%0d got %b exp %b", c, ex_valid, (c == 1)); end
      if (c == 1) begin
        n_checks++; if ({ex_op, ex_a, ex_b} !== {4'h0, 32'h3F800000, 32'h40000000}) begin n_fail++; $display("[TB] FAIL single_ex_fields got %h %h %h exp 0 3f800000 40000000", ex_op, ex_a, ex_b); end
      end
      n_checks++; if (rsp_valid !== ((c == 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("[TB] FAIL single_rsp_valid c=%0d got %b exp %b", c, rsp_valid, (c == 4) ? 2'b01 : 2'b00); end
      if (c == 4) begin
        n_checks++; if (rsp_result !== eu_fn('0, 32'h3F800000, 32'h40000000, 32'h0)) begin n_fail++; $display("[TB] FAIL single_rsp_result got %h exp %h", rsp_result, eu_fn('0, 32'h3F800000, 32'h40000000, 32'h0)); end
      end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("[TB] FAIL single_busy c=%0d got %b exp %b", c, busy, e_busy); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] prev;
    prev = '0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle('1, 1'b0);
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("[TB] FAIL rr_ready c=%0d got %b exp %b", c, req_ready, e_ready); end
      if (c > 0) begin
        n_checks++; if (req_ready !== ~prev) begin n_fail++; $display("[TB] FAIL rr_alternate c=%0d got %b exp %b", c, req_ready, ~prev); end
      end
      prev = req_ready;
      n_checks++; if (ex_valid !== m_issued) begin n_fail++; $display("[TB] FAIL rr_ex_valid c=%0d got %b exp %b", c, ex_valid, m_issued); end
      if (m_issued) begin
        n_checks++; if ({ex_op, ex_a, ex_b, ex_c} !== {m_op, m_a, m_b, m_c}) begin n_fail++; $display("[TB] FAIL rr_ex_fields c=%0d got %h %h exp %h %h", c, ex_op, ex_c, m_op, m_c); end
      end
      n_checks++; if (rsp_valid !== e_rsp) begin n_fail++; $display("[TB] FAIL rr_rsp_valid c=%0d got %b exp %b", c, rsp_valid, e_rsp); end
      if (c >= 1 + LATENCY) begin
        n_checks++; if (rsp_valid == '0) begin n_fail++; $display("[TB] FAIL rr_rsp_stream c=%0d got %b exp one-hot", c, rsp_valid); end
      end
      if (e_rsp != '0) begin
        n_checks++; if ({rsp_result, rsp_flags} !== {e_res, e_flg}) begin n_fail++; $display("[TB] FAIL rr_rsp_data c=%0d got %h/%h exp %h/%h", c, rsp_result, rsp_flags, e_res, e_flg); end
      end
      tick();
    end
  endtask

  task automatic test_credits();
    idle_cycles(8);
    for (int c = 0; c < 14; c++) begin
      drive_cycle(2'b10, 1'b0);
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("[TB] FAIL credit_ready c=%0d got %b exp %b", c, req_ready, e_ready); end
      n_checks++; if (req_ready !== (((c % 4) < 2) ? 2'b10 : 2'b00)) begin n_fail++; $display("[TB] FAIL credit_pattern c=%0d got %b exp %b", c, req_ready, ((c % 4) < 2) ? 2'b10 : 2'b00); end
      n_checks++; if (rsp_valid !== ((c >= 4 && (c % 4) < 2) ? 2'b10 : 2'b00)) begin n_fail++; $display("[TB] FAIL credit_rsp c=%0d got %b exp %b", c, rsp_valid, (c >= 4 && (c % 4) < 2) ? 2'b10 : 2'b00); end
      if (e_rsp != '0) begin
        n_checks++; if (rsp_result !== e_res) begin n_fail++; $display("[TB] FAIL credit_rsp_result c=%0d got %h exp %h", c, rsp_result, e_res); end
      end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("[TB] FAIL credit_busy c=%0d got %b exp %b", c, busy, e_busy); end
      tick();
    end
  endtask

  task automatic test_flush();
    idle_cycles(8);
    for (int c = 0; c < 13; c++) begin
      drive_cycle('1, c == 3);
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("[TB] FAIL flush_ready c=%0d got %b exp %b", c, req_ready, e_ready); end
      if (c >= 3 && c <= 7) begin
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_gated c=%0d got %b exp 00", c, req_ready); end
      end
      if (c == 8) begin
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL flush_rr_restart got %b exp 01", req_ready); end
      end
      n_checks++; if (flush_done !== (c == 7)) begin n_fail++; $display("[TB] FAIL flush_done c=%0d got %b exp %b", c, flush_done, (c == 7)); end
      n_checks++; if (flush_done !== e_fd) begin n_fail++; $display("[TB] FAIL flush_done_model c=%0d got %b exp %b", c, flush_done, e_fd); end
      n_checks++; if (rsp_valid !== e_rsp) begin n_fail++; $display("[TB] FAIL flush_rsp c=%0d got %b exp %b", c, rsp_valid, e_rsp); end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("[TB] FAIL flush_busy c=%0d got %b exp %b", c, busy, e_busy); end
      tick();
    end
  endtask

  task automatic test_idle_flush();
    idle_cycles(8);
    for (int c = 0; c < 5; c++) begin
      drive_cycle('0, c == 0);
      n_checks++; if (flush_done !== (c == 1)) begin n_fail++; $display("[TB] FAIL idle_flush_done c=%0d got %b exp %b", c, flush_done, (c == 1)); end
      n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_flush_ex_valid c=%0d got %b exp 0", c, ex_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_flush_busy c=%0d got %b exp 0", c, busy); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_cycles(8);
    drive_cycle(2'b01, 1'b0);
    n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("[TB] FAIL rstmid_accept got %b exp %b", req_ready, e_ready); end
    tick();
    drive_cycle('0, 1'b0);
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ex_valid got %b exp 1", ex_valid); end
    tick();
    req_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ex_valid, busy, flush_done} !== 3'b000) begin n_fail++; $display("[TB] FAIL rstmid_outputs got ex_valid=%b busy=%b flush_done=%b exp 000", ex_valid, busy, flush_done); end
    n_checks++; if ({req_ready, rsp_valid} !== '0) begin n_fail++; $display("[TB] FAIL rstmid_handshake got ready=%b rsp=%b exp 0", req_ready, rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < LATENCY + 4; c++) begin
      drive_cycle('0, 1'b0);
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL rstmid_no_rsp c=%0d got %b exp 00", c, rsp_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_busy c=%0d got %b exp 0", c, busy); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c < 385) drive_cycle(N_REQ'($urandom), $urandom_range(0, 24) == 0);
      else         drive_cycle('0, 1'b0);
      n_checks++; if (req_ready !== e_ready) begin n_fail++; $display("[TB] FAIL rand_ready c=%0d got %b exp %b", c, req_ready, e_ready); end
      n_checks++; if (ex_valid !== m_issued) begin n_fail++; $display("[TB] FAIL rand_ex_valid c=%0d got %b exp %b", c, ex_valid, m_issued); end
      if (m_issued) begin
        n_checks++; if ({ex_op, ex_a, ex_b, ex_c} !== {m_op, m_a, m_b, m_c}) begin n_fail++; $display("[TB] FAIL rand_ex_fields c=%0d got %h %h %h %h exp %h %h %h %h", c, ex_op, ex_a, ex_b, ex_c, m_op, m_a, m_b, m_c); end
      end
      n_checks++; if (rsp_valid !== e_rsp) begin n_fail++; $display("[TB] FAIL rand_rsp_valid c=%0d got %b exp %b", c, rsp_valid, e_rsp); end
      if (e_rsp != '0) begin
        n_checks++; if ({rsp_result, rsp_flags} !== {e_res, e_flg}) begin n_fail++; $display("[TB] FAIL rand_rsp_data c=%0d got %h/%h exp %h/%h", c, rsp_result, rsp_flags, e_res, e_flg); end
      end
      n_checks++; if (flush_done !== e_fd) begin n_fail++; $display("[TB] FAIL rand_flush_done c=%0d got %b exp %b", c, flush_done, e_fd); end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("[TB] FAIL rand_busy c=%0d got %b exp %b", c, busy, e_busy); end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    flush_req = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    cyc       = 0;
    model_reset();
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("[TB] reset released");
    test_single_op();
    test_round_robin();
    test_credits();
    test_flush();
    test_idle_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
